// File: rtl/mul_ctrl_pkg.sv
// Shared types and constants for the multiplier issue controller.
// Tags are carried at TAG_MAX_W bits; the controller's TAG_W may not exceed it.
package mul_ctrl_pkg;

    localparam int MUL_W     = 32;
    localparam int PROD_W    = 64;
    localparam int TAG_MAX_W = 4;

    typedef struct packed {
        logic                 valid;
        logic                 id;
        logic [TAG_MAX_W-1:0] tag;
        logic                 neg;
    } shadow_t;

    typedef struct packed {
        logic [PROD_W-1:0]    prod;
        logic                 id;
        logic [TAG_MAX_W-1:0] tag;
    } rsp_entry_t;

    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [MUL_W-1:0] magnitude(input logic [MUL_W-1:0] v);
        return v[MUL_W-1] ? (~v + MUL_W'(1)) : v;
    endfunction

endpackage

// File: rtl/mul_rsp_fifo.sv
// Response FIFO: storage array plus a registered head stage (first-word-fall-through).
// count covers the storage and the head register, so it is the full occupancy.
module mul_rsp_fifo
    import mul_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  rsp_entry_t               push_data,
    input  logic                     pop,
    output logic                     head_valid,
    output rsp_entry_t               head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    rsp_entry_t    mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   mem_count;
    logic          mem_empty;
    logic          full;
    logic          pop_out;
    logic          load_out;
    logic          wr_en;

    assign mem_count = wr_ptr - rd_ptr;
    assign mem_empty = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_out   = head_valid & pop;
    assign load_out  = (~head_valid | pop_out) & ~mem_empty;
    assign wr_en     = push & ~full;
    assign count     = mem_count + (AW+1)'(head_valid);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            head_valid <= 1'b0;
            head       <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (load_out) begin
                rd_ptr     <= rd_ptr + (AW+1)'(1);
                head       <= mem[rd_ptr[AW-1:0]];
                head_valid <= 1'b1;
            end else if (pop_out) begin
                head_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Round-robin issue controller for the shared pipelined multiplier with credit-based admission.
// Optional signed operation is enabled by defining MUL_CTRL_SIGNED_EN.
module mul_issue_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int LATENCY    = 10,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [MUL_W-1:0]  req0_a,
    input  logic [MUL_W-1:0]  req0_b,
    input  logic [TAG_W-1:0]  req0_tag,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [MUL_W-1:0]  req1_a,
    input  logic [MUL_W-1:0]  req1_b,
    input  logic [TAG_W-1:0]  req1_tag,
`ifdef MUL_CTRL_SIGNED_EN
    input  logic              req0_signed,
    input  logic              req1_signed,
`endif
    output logic [MUL_W-1:0]  mul_a,
    output logic [MUL_W-1:0]  mul_b,
    input  logic [PROD_W-1:0] mul_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [PROD_W-1:0] rsp_prod,
    output logic              rsp_id,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    shadow_t          shadow [LATENCY];
    logic [CW-1:0]    fifo_count;
    logic [CW-1:0]    inflight_count;
    logic [CW:0]      outstanding;
    logic             rr_ptr;
    logic             credit_ok;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic             accept_id;
    logic             capture;
    logic [MUL_W-1:0] sel_a;
    logic [MUL_W-1:0] sel_b;
    logic [TAG_MAX_W-1:0] sel_tag;
    logic             sel_neg;
    rsp_entry_t       push_data;
    rsp_entry_t       head;

    // Everything admitted but not yet popped holds a credit.
    assign outstanding = {1'b0, fifo_count} + {1'b0, inflight_count};
    assign credit_ok   = outstanding < (CW+1)'(FIFO_DEPTH);

    assign grant0     = req0_valid & (~req1_valid | ~rr_ptr);
    assign grant1     = req1_valid & (~req0_valid | rr_ptr);
    assign req0_ready = ~rst & credit_ok & grant0;
    assign req1_ready = ~rst & credit_ok & grant1;
    assign accept_id  = req1_valid & req1_ready;
    assign accept     = (req0_valid & req0_ready) | accept_id;

    always_comb begin
        sel_a   = accept_id ? req1_a : req0_a;
        sel_b   = accept_id ? req1_b : req0_b;
        sel_tag = accept_id ? TAG_MAX_W'(req1_tag) : TAG_MAX_W'(req0_tag);
        sel_neg = 1'b0;
`ifdef MUL_CTRL_SIGNED_EN
        if (accept_id ? req1_signed : req0_signed) begin
            sel_neg = sel_a[MUL_W-1] ^ sel_b[MUL_W-1];
            sel_a   = magnitude(sel_a);
            sel_b   = magnitude(sel_b);
        end
`endif
    end

    assign capture = shadow[LATENCY-1].valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a          <= '0;
            mul_b          <= '0;
            rr_ptr         <= 1'b0;
            inflight_count <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            if (accept) begin
                mul_a  <= sel_a;
                mul_b  <= sel_b;
                rr_ptr <= ~accept_id;
            end
            shadow[0] <= '{valid: accept, id: accept_id, tag: sel_tag, neg: sel_neg};
            for (int i = 1; i < LATENCY; i++) begin
                shadow[i] <= shadow[i-1];
            end
            case ({accept, capture})
                2'b10:   inflight_count <= inflight_count + CW'(1);
                2'b01:   inflight_count <= inflight_count - CW'(1);
                default: inflight_count <= inflight_count;
            endcase
        end
    end

    assign push_data = '{
        prod: shadow[LATENCY-1].neg ? (~mul_out + PROD_W'(1)) : mul_out,
        id:   shadow[LATENCY-1].id,
        tag:  shadow[LATENCY-1].tag
    };

    mul_rsp_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (capture),
        .push_data  (push_data),
        .pop        (rsp_ready),
        .head_valid (rsp_valid),
        .head       (head),
        .count      (fifo_count)
    );

    assign rsp_prod = head.prod;
    assign rsp_id   = head.id;
    assign rsp_tag  = head.tag[TAG_W-1:0];
    assign busy     = (inflight_count != '0) | (fifo_count != '0);

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Testbench for mul_issue_ctrl: behavioural multiplier, transaction-level reference model, scenario tasks.
// Exercises the signed path when MUL_CTRL_SIGNED_EN is defined.
module tb_mul_issue_ctrl;

    localparam int L  = 10;
    localparam int D  = 4;
    localparam int TW = 4;
`ifdef MUL_CTRL_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0]   req0_a, req0_b, req1_a, req1_b;
    logic [TW-1:0] req0_tag, req1_tag;
    logic          req0_signed, req1_signed;
    logic [31:0]   mul_a, mul_b;
    logic [63:0]   mul_out;
    logic          rsp_valid, rsp_ready;
    logic [63:0]   rsp_prod;
    logic          rsp_id;
    logic [TW-1:0] rsp_tag;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    mul_issue_ctrl #(.LATENCY(L), .FIFO_DEPTH(D), .TAG_W(TW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_tag   (req0_tag),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_tag   (req1_tag),
`ifdef MUL_CTRL_SIGNED_EN
        .req0_signed(req0_signed),
        .req1_signed(req1_signed),
`endif
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_out    (mul_out),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_prod   (rsp_prod),
        .rsp_id     (rsp_id),
        .rsp_tag    (rsp_tag),
        .busy       (busy)
    );

    // Multiplier stand-in: mul_a/mul_b are the first register, so L-1 more follow.
    logic [63:0] mpipe [L-1];
    always @(posedge clk) begin
        mpipe[0] <= {32'b0, mul_a} * {32'b0, mul_b};
        for (int i = 1; i < L-1; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_out = mpipe[L-2];

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input bit sg);
        logic signed [63:0] sa, sb;
        if (sg) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return sa * sb;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    // Reference model: ordered list of admitted ops, each visible no earlier than L+1 edges after acceptance.
    typedef struct {
        logic [63:0]   prod;
        logic          id;
        logic [TW-1:0] tag;
        int            rdy;
    } exp_t;
    exp_t exp_q[$];
    exp_t m_new;
    int   m_out = 0;
    bit   m_ptr = 1'b0;
    bit   m_credit, m_g0, m_g1, m_v;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_out = 0;
            m_ptr = 1'b0;
            n_checks++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL ready_in_reset: got %b%b expected 00", req0_ready, req1_ready);
            end
        end else begin
            m_credit = (m_out < D);
            m_g0 = m_credit && req0_valid && (!req1_valid || !m_ptr);
            m_g1 = m_credit && req1_valid && (!req0_valid || m_ptr);
            if (req0_valid) begin
                n_checks++;
                if (req0_ready !== m_g0) begin
                    n_fail++;
                    $display("FAIL req0_ready: got %b expected %b at edge %0d", req0_ready, m_g0, edge_cnt);
                end
            end
            if (req1_valid) begin
                n_checks++;
                if (req1_ready !== m_g1) begin
                    n_fail++;
                    $display("FAIL req1_ready: got %b expected %b at edge %0d", req1_ready, m_g1, edge_cnt);
                end
            end
            n_checks++;
            if (req0_ready === 1'b1 && req1_ready === 1'b1) begin
                n_fail++;
                $display("FAIL one_ready: got both ready expected at most one");
            end
            m_v = (exp_q.size() > 0) && (edge_cnt >= exp_q[0].rdy);
            n_checks++;
            if (rsp_valid !== m_v) begin
                n_fail++;
                $display("FAIL rsp_valid: got %b expected %b at edge %0d", rsp_valid, m_v, edge_cnt);
            end
            if (m_v && rsp_valid === 1'b1) begin
                n_checks++;
                if (rsp_prod !== exp_q[0].prod || rsp_id !== exp_q[0].id || rsp_tag !== exp_q[0].tag) begin
                    n_fail++;
                    $display("FAIL rsp_data: got %h/%0d/%h expected %h/%0d/%h", rsp_prod, rsp_id, rsp_tag,
                             exp_q[0].prod, exp_q[0].id, exp_q[0].tag);
                end
            end
            if (m_v && rsp_ready) begin
                void'(exp_q.pop_front());
                m_out--;
            end
            if (m_g0 || m_g1) begin
                m_new.prod = m_g0 ? ref_prod(req0_a, req0_b, SIGNED_EN && req0_signed)
                                  : ref_prod(req1_a, req1_b, SIGNED_EN && req1_signed);
                m_new.id   = m_g1;
                m_new.tag  = m_g0 ? req0_tag : req1_tag;
                m_new.rdy  = edge_cnt + L + 2;
                exp_q.push_back(m_new);
                m_out++;
                m_ptr = m_g0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one op on the given requester and waits for its response; the response is popped on return.
    task automatic run_single(input bit id, input logic [31:0] a, input logic [31:0] b, input logic [TW-1:0] tag,
                              input bit sg, output bit seen, output int lat, output logic [63:0] prod,
                              output logic rid, output logic [TW-1:0] rtag, output logic busy_at);
        int e = -1;
        seen = 1'b0; lat = -1; prod = '0; rid = 1'b0; rtag = '0; busy_at = 1'b0;
        rsp_ready = 1'b1;
        if (id) begin req1_a = a; req1_b = b; req1_tag = tag; req1_signed = sg; req1_valid = 1'b1; end
        else    begin req0_a = a; req0_b = b; req0_tag = tag; req0_signed = sg; req0_valid = 1'b1; end
        for (int k = 0; k < 20 && e < 0; k++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) e = edge_cnt + 1;
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (e < 0) return;
        for (int k = 0; k < L + 8 && !seen; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1'b1; lat = edge_cnt - e; prod = rsp_prod; rid = rsp_id; rtag = rsp_tag; busy_at = busy;
            end
            tick();
        end
    endtask

    task automatic drain(output bit idle);
        idle = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        for (int k = 0; k < 80 && !idle; k++) begin
            @(negedge clk);
            idle = (busy === 1'b0);
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (mul_a !== 32'd0 || mul_b !== 32'd0) begin n_fail++; $display("FAIL reset_mul_ab: got %h %h expected 0 0", mul_a, mul_b); end
        tick();
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_single_op();
        bit seen; int lat; logic [63:0] p; logic rid; logic [TW-1:0] rt; logic b_at;
        run_single(1'b0, 32'd3, 32'd5, 4'hA, 1'b0, seen, lat, p, rid, rt, b_at);
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL single_timeout: got no response expected one"); return; end
        n_checks++; if (lat !== L + 1) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d", lat, L + 1); end
        n_checks++; if (p !== 64'd15 || rid !== 1'b0 || rt !== 4'hA) begin n_fail++; $display("FAIL single_data: got %h/%0d/%h expected f/0/a", p, rid, rt); end
        n_checks++; if (b_at !== 1'b1) begin n_fail++; $display("FAIL single_busy_high: got %b expected 1", b_at); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_drop: got %b expected 0", busy); end
        tick();
    endtask

    task automatic test_max_unsigned();
        bit seen; int lat; logic [63:0] p; logic rid; logic [TW-1:0] rt; logic b_at;
        run_single(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h3, 1'b0, seen, lat, p, rid, rt, b_at);
        n_checks++;
        if (!seen || p !== 64'hFFFF_FFFE_0000_0001 || rid !== 1'b1 || rt !== 4'h3) begin
            n_fail++; $display("FAIL max_unsigned: got %h/%0d/%h expected fffffffe00000001/1/3", p, rid, rt);
        end
    endtask

`ifdef MUL_CTRL_SIGNED_EN
    task automatic test_signed();
        bit seen; int lat; logic [63:0] p; logic rid; logic [TW-1:0] rt; logic b_at;
        run_single(1'b0, 32'hFFFF_FFFD, 32'd7, 4'h1, 1'b1, seen, lat, p, rid, rt, b_at);
        n_checks++;
        if (!seen || p !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_fail++; $display("FAIL signed_neg: got %h expected ffffffffffffffeb", p); end
        run_single(1'b1, 32'h8000_0000, 32'h8000_0000, 4'h2, 1'b1, seen, lat, p, rid, rt, b_at);
        n_checks++;
        if (!seen || p !== 64'h4000_0000_0000_0000) begin n_fail++; $display("FAIL signed_min: got %h expected 4000000000000000", p); end
        req0_signed = 1'b0; req1_signed = 1'b0;
    endtask
`endif

    task automatic test_contention();
        int  ids[8];
        int  n = 0;
        int  who;
        bit  idle;
        rsp_ready = 1'b1;
        req0_a = $urandom; req0_b = $urandom; req0_tag = 4'(n);
        req1_a = $urandom; req1_b = $urandom; req1_tag = 4'(n + 8);
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int k = 0; k < 200 && n < 8; k++) begin
            @(negedge clk);
            who = -1;
            if (req0_ready) who = 0;
            else if (req1_ready) who = 1;
            if (who >= 0) begin ids[n] = who; n++; end
            tick();
            if (who == 0) begin req0_a = $urandom; req0_b = $urandom; req0_tag = 4'(n); end
            if (who == 1) begin req1_a = $urandom; req1_b = $urandom; req1_tag = 4'(n + 8); end
        end
        n_checks++;
        if (n != 8) begin n_fail++; $display("FAIL contention_count: got %0d accepts expected 8", n); end
        for (int k = 0; k < n; k++) begin
            n_checks++;
            if (ids[k] != (k % 2)) begin n_fail++; $display("FAIL contention_order: accept %0d got id %0d expected %0d", k, ids[k], k % 2); end
        end
        drain(idle);
        n_checks++; if (!idle) begin n_fail++; $display("FAIL contention_drain: busy got 1 expected 0"); end
    endtask

    task automatic test_backpressure();
        int  n_acc = 0;
        int  late_ready = 0;
        int  n_rsp = 0;
        bit  idle;
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = $urandom; req0_b = $urandom; req0_tag = 4'h5;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (req0_ready) n_acc++;
            if (k >= 15 && req0_ready) late_ready++;
            tick();
            req0_a = $urandom; req0_b = $urandom; req0_tag = 4'(k);
        end
        req0_valid = 1'b0;
        n_checks++; if (n_acc != D) begin n_fail++; $display("FAIL bp_accepts: got %0d expected %0d", n_acc, D); end
        n_checks++; if (late_ready != 0) begin n_fail++; $display("FAIL bp_ready_low: got %0d ready cycles expected 0", late_ready); end
        rsp_ready = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (rsp_valid) n_rsp++;
            tick();
        end
        n_checks++; if (n_rsp != D) begin n_fail++; $display("FAIL bp_responses: got %0d expected %0d", n_rsp, D); end
        drain(idle);
        n_checks++; if (!idle) begin n_fail++; $display("FAIL bp_drain: busy got 1 expected 0"); end
    endtask

    task automatic test_random();
        bit idle;
        for (int c = 0; c < 400; c++) begin
            req0_valid = 1'($urandom_range(0, 1)); req1_valid = 1'($urandom_range(0, 1));
            req0_a = $urandom; req0_b = $urandom; req0_tag = 4'($urandom);
            req1_a = $urandom; req1_b = $urandom; req1_tag = 4'($urandom);
            req0_signed = 1'($urandom_range(0, 1)); req1_signed = 1'($urandom_range(0, 1));
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain(idle);
        n_checks++; if (!idle) begin n_fail++; $display("FAIL random_drain: busy got 1 expected 0"); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL random_lost: got %0d undelivered expected 0", exp_q.size()); end
        req0_signed = 1'b0; req1_signed = 1'b0;
    endtask

    task automatic test_mid_reset();
        int n = 0;
        int n_rsp = 0;
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = $urandom; req0_b = $urandom; req0_tag = 4'h7;
        for (int k = 0; k < 30 && n < 3; k++) begin
            @(negedge clk);
            if (req0_ready) n++;
            tick();
            req0_a = $urandom; req0_b = $urandom;
        end
        req0_valid = 1'b0;
        n_checks++; if (n != 3) begin n_fail++; $display("FAIL midrst_issue: got %0d accepts expected 3", n); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_checks++; if (mul_a !== 32'd0 || mul_b !== 32'd0) begin n_fail++; $display("FAIL midrst_mul_ab: got %h %h expected 0 0", mul_a, mul_b); end
        tick();
        for (int k = 0; k < L + 6; k++) begin
            @(negedge clk);
            if (rsp_valid) n_rsp++;
            tick();
        end
        n_checks++; if (n_rsp != 0) begin n_fail++; $display("FAIL midrst_no_rsp: got %0d responses expected 0", n_rsp); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_tag = '0; req0_signed = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_tag = '0; req1_signed = 1'b0;
        rsp_ready = 1'b0;
        test_reset();
        test_single_op();
        test_max_unsigned();
`ifdef MUL_CTRL_SIGNED_EN
        test_signed();
`endif
        test_contention();
        test_backpressure();
        test_random();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
